mandel_result_arbiter: RTL and testbench

- Sits directly upstream of the worker-to-VGA FIFO.
- Collects finished pixel results from NUM_WORKERS Mandelbrot workers over valid/ready handshakes and arbitrates between them round-robin.
- Packs each result into one DATA_WIDTH word and writes it into the FIFO through a registered output stage, never asserting write while the FIFO reports full.
- Counts written pixels and flags end of frame.

---
 rtl/mandel_pkg.sv | 23 ++
 rtl/mandel_result_arbiter_if.sv | 28 ++
 rtl/mandel_result_arbiter_rr_arbiter.sv | 30 +++
 rtl/mandel_result_arbiter.sv | 81 ++++++++
 tb/tb_mandel_result_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// Shared constants and the packed FIFO word layout for the Mandelbrot result path.
// The VGA-side unpacker imports the same struct so both ends agree on field positions.
package mandel_pkg;

  localparam int DEF_NUM_WORKERS  = 4;
  localparam int DEF_ADDR_WIDTH   = 19;
  localparam int DEF_ITER_WIDTH   = 8;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_FRAME_PIXELS = 307200;
  localparam int DEF_WID_WIDTH    = $clog2(DEF_NUM_WORKERS);

  localparam int ITER_LSB = 0;
  localparam int ADDR_LSB = ITER_LSB + DEF_ITER_WIDTH;
  localparam int WID_LSB  = ADDR_LSB + DEF_ADDR_WIDTH;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-WID_LSB-DEF_WID_WIDTH-1:0] pad;
    logic [DEF_WID_WIDTH-1:0]                        wid;
    logic [DEF_ADDR_WIDTH-1:0]                       addr;
    logic [DEF_ITER_WIDTH-1:0]                       iter;
  } mandel_result_t;

endpackage

// File: rtl/mandel_result_arbiter_if.sv
// Worker result bus plus FIFO write port for the result arbiter.
// Handshake: a worker result transfers in any cycle where res_valid[i] && res_ready[i];
// the worker holds valid/addr/iter stable until then. fifo_wr is a plain strobe, only
// ever high while fifo_full is low.
interface mandel_result_arbiter_if #(
  parameter int NUM_WORKERS = mandel_pkg::DEF_NUM_WORKERS,
  parameter int ADDR_WIDTH  = mandel_pkg::DEF_ADDR_WIDTH,
  parameter int ITER_WIDTH  = mandel_pkg::DEF_ITER_WIDTH,
  parameter int DATA_WIDTH  = mandel_pkg::DEF_DATA_WIDTH
);
  logic [NUM_WORKERS-1:0]            res_valid;
  logic [NUM_WORKERS-1:0]            res_ready;
  logic [NUM_WORKERS*ADDR_WIDTH-1:0] res_addr;
  logic [NUM_WORKERS*ITER_WIDTH-1:0] res_iter;
  logic                              fifo_full;
  logic                              fifo_wr;
  logic [DATA_WIDTH-1:0]             fifo_data;

  modport master (
    output res_valid, res_addr, res_iter, fifo_full,
    input  res_ready, fifo_wr, fifo_data
  );

  modport slave (
    input  res_valid, res_addr, res_iter, fifo_full,
    output res_ready, fifo_wr, fifo_data
  );
endinterface

// File: rtl/mandel_result_arbiter_rr_arbiter.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping.
// N must be a power of two so the index arithmetic wraps for free.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + IDX_W'(i);
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/mandel_result_arbiter.sv
// Round-robin collector of worker pixel results into the worker-to-VGA FIFO, with a
// single registered output slot and a per-frame pixel counter.
module mandel_result_arbiter
  import mandel_pkg::*;
#(
  parameter int NUM_WORKERS  = DEF_NUM_WORKERS,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int ITER_WIDTH   = DEF_ITER_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
  input  logic                            clk,
  input  logic                            rst,
  mandel_result_arbiter_if.slave          bus,
  output logic [$clog2(FRAME_PIXELS)-1:0] pixel_count,
  output logic                            frame_done
);
  localparam int IDX_W  = $clog2(NUM_WORKERS);
  localparam int CNT_W  = $clog2(FRAME_PIXELS);
  localparam int A_LSB  = ITER_LSB + ITER_WIDTH;
  localparam int W_LSB  = A_LSB + ADDR_WIDTH;
  localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(FRAME_PIXELS - 1);

  logic [DATA_WIDTH-1:0]  out_word;
  logic                   out_valid;
  logic [IDX_W-1:0]       ptr;
  logic [NUM_WORKERS-1:0] grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   slot_free;
  logic                   wr;
  logic [DATA_WIDTH-1:0]  next_word;

  // The slot can take a new word if empty or if its current word drains this cycle.
  assign slot_free = !out_valid || !bus.fifo_full;
  assign grant_any = |grant;

  rr_arbiter #(.N(NUM_WORKERS), .IDX_W(IDX_W)) u_rr (
    .req       (bus.res_valid),
    .ptr       (ptr),
    .enable    (slot_free && !rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    next_word = '0;
    next_word[ITER_LSB +: ITER_WIDTH] = bus.res_iter[int'(grant_idx)*ITER_WIDTH +: ITER_WIDTH];
    next_word[A_LSB +: ADDR_WIDTH]    = bus.res_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    next_word[W_LSB +: IDX_W]         = grant_idx;
  end

  // Gated by rst so a word held across reset is dropped rather than written.
  assign wr            = out_valid && !bus.fifo_full && !rst;
  assign bus.fifo_wr   = wr;
  assign bus.fifo_data = rst ? '0 : out_word;
  assign bus.res_ready = grant;
  assign frame_done    = wr && (pixel_count == LAST_PIXEL);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_word    <= '0;
      ptr         <= '0;
      pixel_count <= '0;
    end else begin
      if (slot_free) begin
        if (grant_any) begin
          out_word  <= next_word;
          out_valid <= 1'b1;
          ptr       <= grant_idx + 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (wr) begin
        pixel_count <= (pixel_count == LAST_PIXEL) ? '0 : pixel_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mandel_result_arbiter.sv
// Directed bench for mandel_result_arbiter with a small frame (8 pixels) so the
// frame wrap is reachable; protocol rules are checked every cycle.
module tb_mandel_result_arbiter;
  localparam int NW = 4;
  localparam int AW = 19;
  localparam int IW = 8;
  localparam int DW = 32;
  localparam int FP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pixel_count;
  logic       frame_done;

  int tests_run = 0;
  int failures  = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mandel_result_arbiter_if #(.NUM_WORKERS(NW), .ADDR_WIDTH(AW), .ITER_WIDTH(IW),
                             .DATA_WIDTH(DW)) bus ();

  mandel_result_arbiter #(
    .NUM_WORKERS(NW), .ADDR_WIDTH(AW), .ITER_WIDTH(IW), .DATA_WIDTH(DW), .FRAME_PIXELS(FP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .pixel_count (pixel_count),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word layout: worker id at bit 27, addr at bit 8, iter at bit 0.
  function automatic logic [DW-1:0] exp_word(input int w);
    logic [DW-1:0] wid, addr, iter;
    wid  = DW'(w);
    addr = DW'(12'h100 + w);
    iter = DW'(8'h10 + w);
    return (wid << 27) | (addr << 8) | iter;
  endfunction

  task automatic load_workers();
    for (int i = 0; i < NW; i++) begin
      bus.res_addr[i*AW +: AW] = AW'(12'h100 + i);
      bus.res_iter[i*IW +: IW] = IW'(8'h10 + i);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    bus.res_valid = '0;
    bus.fifo_full = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    check("wr_on_full", 32'(bus.fifo_wr & bus.fifo_full), 32'd0);
    check("ready_onehot", 32'($onehot0(bus.res_ready)), 32'd1);
    check("ready_on_valid", 32'(bus.res_ready & ~bus.res_valid), 32'd0);
  end

  initial begin
    logic [NW-1:0] rdy_exp;
    logic [2:0]    pc_exp;

    rst = 1'b1;
    bus.res_valid = '0;
    bus.fifo_full = 1'b0;
    bus.res_addr  = '0;
    bus.res_iter  = '0;
    next_cycle();

    // Reset values
    #1;
    check("rst_ready", 32'(bus.res_ready), 32'd0);
    check("rst_wr", 32'(bus.fifo_wr), 32'd0);
    check("rst_data", bus.fifo_data, 32'd0);
    check("rst_pc", 32'(pixel_count), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Single worker 2
    bus.res_addr[2*AW +: AW] = 19'h00123;
    bus.res_iter[2*IW +: IW] = 8'h45;
    bus.res_valid = 4'b0100;
    #1;
    check("single_ready", 32'(bus.res_ready), 32'b0100);
    check("single_wr_k", 32'(bus.fifo_wr), 32'd0);
    next_cycle();
    bus.res_valid = '0;
    #1;
    check("single_wr", 32'(bus.fifo_wr), 32'd1);
    check("single_data", bus.fifo_data, 32'h1001_2345);
    check("single_ready_idle", 32'(bus.res_ready), 32'd0);
    next_cycle();
    #1;
    check("single_pc", 32'(pixel_count), 32'd1);
    check("single_wr_done", 32'(bus.fifo_wr), 32'd0);
    next_cycle();

    // All workers continuously valid
    pulse_reset();
    load_workers();
    bus.res_valid = 4'hF;
    for (int j = 0; j < 8; j++) begin
      #1;
      rdy_exp = 4'b0001 << (j % 4);
      check("rr_ready", 32'(bus.res_ready), 32'(rdy_exp));
      check("rr_wr", 32'(bus.fifo_wr), 32'(j > 0));
      check("rr_pc", 32'(pixel_count), (j == 0) ? 32'd0 : 32'(j - 1));
      if (bus.fifo_wr && exp_q.size() > 0) check("rr_data", bus.fifo_data, exp_q.pop_front());
      exp_q.push_back(exp_word(j % 4));
      next_cycle();
    end
    bus.res_valid = '0;
    #1;
    check("rr_wr_last", 32'(bus.fifo_wr), 32'd1);
    if (exp_q.size() > 0) check("rr_data_last", bus.fifo_data, exp_q.pop_front());
    check("rr_queue_empty", 32'(exp_q.size()), 32'd0);
    next_cycle();

    // Backpressure for five cycles
    pulse_reset();
    load_workers();
    bus.res_valid = 4'hF;
    #1;
    check("bp_first_ready", 32'(bus.res_ready), 32'b0001);
    next_cycle();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready", 32'(bus.res_ready), 32'd0);
      check("bp_wr", 32'(bus.fifo_wr), 32'd0);
      check("bp_word", bus.fifo_data, exp_word(0));
      next_cycle();
    end
    bus.fifo_full = 1'b0;
    #1;
    check("bp_release_wr", 32'(bus.fifo_wr), 32'd1);
    check("bp_release_data", bus.fifo_data, exp_word(0));
    check("bp_release_ready", 32'(bus.res_ready), 32'b0010);
    next_cycle();
    #1;
    check("bp_next_wr", 32'(bus.fifo_wr), 32'd1);
    check("bp_next_data", bus.fifo_data, exp_word(1));
    check("bp_next_ready", 32'(bus.res_ready), 32'b0100);
    next_cycle();
    bus.res_valid = '0;
    next_cycle();
    next_cycle();

    // Frame boundary with FRAME_PIXELS=8, ten results
    pulse_reset();
    load_workers();
    bus.res_valid = 4'hF;
    for (int j = 0; j < 12; j++) begin
      if (j == 10) bus.res_valid = '0;
      #1;
      pc_exp = (j == 0) ? 3'd0 : 3'((j - 1) % 8);
      check("frame_done", 32'(frame_done), 32'(j == 8));
      check("frame_pc", 32'(pixel_count), 32'(pc_exp));
      check("frame_wr", 32'(bus.fifo_wr), 32'(j >= 1 && j <= 10));
      next_cycle();
    end

    // Reset mid-operation with a held word; ptr is 2 and pixel_count is 2 here
    bus.res_valid = 4'b0010;
    #1;
    check("mid_pre_pc", 32'(pixel_count), 32'd2);
    check("mid_ready_w1", 32'(bus.res_ready), 32'b0010);
    next_cycle();
    bus.res_valid = 4'b1001;
    bus.fifo_full = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_wr", 32'(bus.fifo_wr), 32'd0);
    check("mid_rst_ready", 32'(bus.res_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    bus.fifo_full = 1'b0;
    #1;
    check("mid_dropped_wr", 32'(bus.fifo_wr), 32'd0);
    check("mid_pc", 32'(pixel_count), 32'd0);
    check("mid_ready_w0", 32'(bus.res_ready), 32'b0001);
    next_cycle();
    bus.res_valid = 4'b1000;
    #1;
    check("mid_wr_w0", 32'(bus.fifo_wr), 32'd1);
    check("mid_data_w0", bus.fifo_data, exp_word(0));
    check("mid_ready_w3", 32'(bus.res_ready), 32'b1000);
    next_cycle();
    bus.res_valid = '0;
    #1;
    check("mid_wr_w3", 32'(bus.fifo_wr), 32'd1);
    check("mid_data_w3", bus.fifo_data, exp_word(3));
    next_cycle();
    #3;

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
